spi_regfile_peripheral: RTL and testbench

Parametrised SPI mode-0 peripheral and register file, the successor to the single-register PWM SPI receiver. It decodes fixed-length frames of the form R/W bit, 7-bit address, DATA_W data bits, and supports both writes and read-back over CIPO. It feeds NUM_REGS configuration registers, for example PWM enables and duty cycles, to the rest of the design. It also reports malformed frames.

---
 rtl/spi_regfile_peripheral.sv | 195 +++++++++++++++++++
 tb/tb_spi_regfile_peripheral.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_regfile_peripheral.sv
// SPI mode-0 peripheral feeding a small register file: frames are R/W, 7-bit address, DATA_W data bits.
// All SPI pins are asynchronous and are synchronised into clk before any decoding.
module spi_regfile_peripheral #(
    parameter int NUM_REGS    = 5,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sclk,
    input  logic                       COPI,
    input  logic                       nCS,
    output logic                       CIPO,
    output logic                       cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic                       wr_strobe,
    output logic [6:0]                 wr_addr,
    output logic                       frame_err
);

    localparam int FL    = 8 + DATA_W;
    localparam int CNT_W = $clog2(FL + 2);
    localparam int SH_W  = (DATA_W > 7) ? DATA_W : 7;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_HDR = CNT_W'(7);
    localparam logic [CNT_W-1:0] CNT_RD  = CNT_W'(9);
    localparam logic [CNT_W-1:0] CNT_FL  = CNT_W'(FL);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(FL + 1);

    typedef enum logic [1:0] {
        IDLE,
        HEADER,
        DATA
    } state_t;

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0]  copi_sync_q, copi_sync_d;
    logic [SYNC_STAGES-1:0]  ncs_sync_q, ncs_sync_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [SH_W-1:0]         shreg_q, shreg_d;
    logic                    rw_q, rw_d;
    logic [6:0]              addr_q, addr_d;
    logic [DATA_W-1:0]       out_q, out_d;
    logic [DATA_W-1:0]       regs_q [NUM_REGS];
    logic [DATA_W-1:0]       regs_d [NUM_REGS];
    logic                    wr_strobe_q, wr_strobe_d;
    logic [6:0]              wr_addr_q, wr_addr_d;
    logic                    frame_err_q, frame_err_d;

    logic                    sclk_rise, sclk_fall, ncs_rise, ncs_fall, copi_s;
    logic [7:0]              hdr_word;
    logic [DATA_W-1:0]       rd_word;

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        copi_sync_d = {copi_sync_q[SYNC_STAGES-2:0], COPI};
        ncs_sync_d  = {ncs_sync_q[SYNC_STAGES-2:0], nCS};
    end

    assign sclk_rise = sclk_sync_q[SYNC_STAGES-2] & ~sclk_sync_q[SYNC_STAGES-1];
    assign sclk_fall = ~sclk_sync_q[SYNC_STAGES-2] & sclk_sync_q[SYNC_STAGES-1];
    assign ncs_rise  = ncs_sync_q[SYNC_STAGES-2] & ~ncs_sync_q[SYNC_STAGES-1];
    assign ncs_fall  = ~ncs_sync_q[SYNC_STAGES-2] & ncs_sync_q[SYNC_STAGES-1];
    assign copi_s    = copi_sync_q[SYNC_STAGES-1];

    // Header as it stands once the 8th bit is shifted in; used to latch rw/addr and pre-load read data.
    assign hdr_word = {shreg_q[6:0], copi_s};

    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (hdr_word[6:0] == 7'(i)) begin
                rd_word = regs_q[i];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        out_d       = out_q;
        regs_d      = regs_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;
        frame_err_d = 1'b0;

        if (ncs_fall) begin
            // A fall outside IDLE aborts the current frame without evaluating it.
            state_d = HEADER;
            cnt_d   = '0;
            shreg_d = '0;
        end else if (ncs_rise) begin
            state_d = IDLE;
            cnt_d   = '0;
            if (cnt_q == CNT_FL) begin
                if (rw_q) begin
                    for (int i = 0; i < NUM_REGS; i++) begin
                        if (addr_q == 7'(i)) begin
                            regs_d[i]   = shreg_q[DATA_W-1:0];
                            wr_strobe_d = 1'b1;
                            wr_addr_d   = addr_q;
                        end
                    end
                end
            end else if (cnt_q != '0) begin
                frame_err_d = 1'b1;
            end
        end else begin
            case (state_q)
                HEADER: begin
                    if (sclk_rise) begin
                        shreg_d = {shreg_q[SH_W-2:0], copi_s};
                        cnt_d   = cnt_q + CNT_ONE;
                        if (cnt_q == CNT_HDR) begin
                            rw_d    = hdr_word[7];
                            addr_d  = hdr_word[6:0];
                            state_d = DATA;
                            if (!hdr_word[7]) begin
                                out_d = rd_word;
                            end
                        end
                    end
                end
                DATA: begin
                    if (sclk_rise) begin
                        // Bits beyond the frame length are dropped so the data field stays intact.
                        if (cnt_q < CNT_FL) begin
                            shreg_d = {shreg_q[SH_W-2:0], copi_s};
                        end
                        if (cnt_q != CNT_SAT) begin
                            cnt_d = cnt_q + CNT_ONE;
                        end
                    end else if (sclk_fall && !rw_q && (cnt_q >= CNT_RD)) begin
                        out_d = out_q << 1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            copi_sync_q <= '0;
            ncs_sync_q  <= '1;
            state_q     <= IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            out_q       <= '0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            frame_err_q <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            sclk_sync_q <= sclk_sync_d;
            copi_sync_q <= copi_sync_d;
            ncs_sync_q  <= ncs_sync_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            out_q       <= out_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
            frame_err_q <= frame_err_d;
            regs_q      <= regs_d;
        end
    end

    always_comb begin
        regs_flat = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_flat[i*DATA_W +: DATA_W] = regs_q[i];
        end
    end

    // Drive CIPO only while a read's data phase is in progress and we are still selected.
    assign cipo_oe   = (state_q == DATA) && !rw_q && !ncs_sync_q[SYNC_STAGES-1];
    assign CIPO      = cipo_oe & out_q[DATA_W-1];
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Bench for spi_regfile_peripheral: two instances (5x8 and 8x16), table vectors, hand sequences and
// random frames checked against a frame-level reference model.
module tb_spi_regfile_peripheral;

    localparam int H = 6;

    logic         clk, rst_n;
    logic         sclk, copi, ncs, sel;
    logic         sclk_a, ncs_a, sclk_b, ncs_b;
    logic         cipo_a, oe_a, stb_a_w, err_a_w;
    logic         cipo_b, oe_b, stb_b_w, err_b_w;
    logic [39:0]  flat_a;
    logic [127:0] flat_b;
    logic [6:0]   wa_a, wa_b;

    assign sclk_a = sel ? 1'b0 : sclk;
    assign ncs_a  = sel ? 1'b1 : ncs;
    assign sclk_b = sel ? sclk : 1'b0;
    assign ncs_b  = sel ? ncs : 1'b1;

    spi_regfile_peripheral #(.NUM_REGS(5), .DATA_W(8), .SYNC_STAGES(2)) dut_a (
        .clk(clk), .rst_n(rst_n), .sclk(sclk_a), .COPI(copi), .nCS(ncs_a),
        .CIPO(cipo_a), .cipo_oe(oe_a), .regs_flat(flat_a), .wr_strobe(stb_a_w),
        .wr_addr(wa_a), .frame_err(err_a_w)
    );

    spi_regfile_peripheral #(.NUM_REGS(8), .DATA_W(16), .SYNC_STAGES(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .sclk(sclk_b), .COPI(copi), .nCS(ncs_b),
        .CIPO(cipo_b), .cipo_oe(oe_b), .regs_flat(flat_b), .wr_strobe(stb_b_w),
        .wr_addr(wa_b), .frame_err(err_b_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int stb_cnt [2];
    int err_cnt [2];
    always @(negedge clk) begin
        if (stb_a_w) stb_cnt[0] = stb_cnt[0] + 1;
        if (err_a_w) err_cnt[0] = err_cnt[0] + 1;
        if (stb_b_w) stb_cnt[1] = stb_cnt[1] + 1;
        if (err_b_w) err_cnt[1] = err_cnt[1] + 1;
    end

    int    n_chk, n_err;
    string tag;

    logic [15:0] m_regs [2][8];
    logic [6:0]  m_last_addr [2];

    typedef struct {
        int          s;
        int          nbits;
        logic [31:0] bits;
        int          stb;
        int          err;
        logic [15:0] rd;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s [%s]: got %0h, expected %0h", name, tag, act, exp);
        end
    endtask

    function automatic logic [127:0] exp_flat(input int s);
        int W = (s != 0) ? 16 : 8;
        int N = (s != 0) ? 8 : 5;
        logic [127:0] r = '0;
        for (int i = 0; i < N; i++) r = r | (128'(m_regs[s][i]) << (i * W));
        return r;
    endfunction

    // Frame-level reference: decide the outcome from the frame length and header, update the model.
    task automatic model_eval(input int s, input int nbits, input logic [31:0] bits,
                              output int stb, output int err, output logic [15:0] rd);
        int W = (s != 0) ? 16 : 8;
        int N = (s != 0) ? 8 : 5;
        int FL = 8 + W;
        logic rw;
        int addr;
        stb = 0; err = 0; rd = '0; rw = 1'b1; addr = 0;
        if (nbits >= 8) begin
            rw   = bits[nbits-1];
            addr = int'((bits >> (nbits - 8)) & 32'h7f);
            if (addr < N) rd = m_regs[s][addr];
        end
        if (nbits == 0) begin
            stb = 0;
        end else if (nbits != FL) begin
            err = 1;
        end else if (rw && addr < N) begin
            m_regs[s][addr] = 16'(bits & ((32'h1 << W) - 32'h1));
            m_last_addr[s]  = 7'(addr);
            stb = 1;
        end
    endtask

    // Expected CIPO / cipo_oe as seen by the controller just before each rising sclk.
    task automatic exp_vec(input int s, input int nbits, input logic [31:0] bits, input logic [15:0] rd,
                           output logic [31:0] cv, output logic [31:0] ov);
        int W = (s != 0) ? 16 : 8;
        logic rw, oe, c;
        cv = '0; ov = '0;
        rw = (nbits > 0) ? bits[nbits-1] : 1'b1;
        for (int k = 1; k <= nbits; k++) begin
            oe = (k >= 9) && !rw;
            c  = 1'b0;
            if (oe && (k - 9) < W) c = rd[W-1-(k-9)];
            cv = {cv[30:0], c};
            ov = {ov[30:0], oe};
        end
    endtask

    task automatic send_frame(input int s, input int nbits, input logic [31:0] bits,
                              output logic [31:0] cv, output logic [31:0] ov,
                              output int dstb, output int derr);
        int s0, e0;
        sel = (s != 0);
        repeat (4) @(negedge clk);
        s0 = stb_cnt[s]; e0 = err_cnt[s];
        cv = '0; ov = '0;
        ncs = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            copi = bits[nbits-1-i];
            repeat (H) @(negedge clk);
            cv = {cv[30:0], (s != 0) ? cipo_b : cipo_a};
            ov = {ov[30:0], (s != 0) ? oe_b : oe_a};
            sclk = 1'b1;
            repeat (H) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (H) @(negedge clk);
        ncs = 1'b1;
        repeat (12) @(negedge clk);
        dstb = stb_cnt[s] - s0;
        derr = err_cnt[s] - e0;
    endtask

    task automatic do_frame(input int s, input int nbits, input logic [31:0] bits, input bit use_tbl,
                            input int t_stb, input int t_err, input logic [15:0] t_rd);
        int m_stb, m_err, dstb, derr;
        logic [15:0] m_rd;
        logic [31:0] cv, ov, ecv, eov;
        logic [127:0] act_flat;
        model_eval(s, nbits, bits, m_stb, m_err, m_rd);
        if (use_tbl) begin
            m_stb = t_stb; m_err = t_err; m_rd = t_rd;
        end
        send_frame(s, nbits, bits, cv, ov, dstb, derr);
        exp_vec(s, nbits, bits, m_rd, ecv, eov);
        if (s != 0) act_flat = flat_b;
        else act_flat = 128'(flat_a);
        chk("cipo_bits", 128'(cv), 128'(ecv));
        chk("cipo_oe", 128'(ov), 128'(eov));
        chk("wr_strobe_pulses", 128'(dstb), 128'(m_stb));
        chk("frame_err_pulses", 128'(derr), 128'(m_err));
        chk("wr_addr", 128'((s != 0) ? wa_b : wa_a), 128'(m_last_addr[s]));
        chk("regs_flat", act_flat, exp_flat(s));
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: time limit reached, errors=%0d", n_err);
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] f;
        int s0, e0;
        n_chk = 0; n_err = 0; tag = "reset";
        stb_cnt[0] = 0; stb_cnt[1] = 0; err_cnt[0] = 0; err_cnt[1] = 0;
        for (int s = 0; s < 2; s++) begin
            m_last_addr[s] = '0;
            for (int i = 0; i < 8; i++) m_regs[s][i] = '0;
        end
        rst_n = 1'b0; sclk = 1'b0; copi = 1'b0; ncs = 1'b1; sel = 1'b0;
        repeat (5) @(negedge clk);
        chk("rst_regs_a", 128'(flat_a), 128'(0));
        chk("rst_regs_b", flat_b, 128'(0));
        chk("rst_cipo", 128'(cipo_a), 128'(0));
        chk("rst_cipo_oe", 128'(oe_a), 128'(0));
        chk("rst_wr_strobe", 128'(stb_a_w), 128'(0));
        chk("rst_frame_err", 128'(err_a_w), 128'(0));
        chk("rst_wr_addr", 128'(wa_a), 128'(0));
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        tbl[0]  = '{0, 16, 32'h80A5,   1, 0, 16'h0000};
        tbl[1]  = '{0, 16, 32'h833C,   1, 0, 16'h0000};
        tbl[2]  = '{0, 16, 32'h0300,   0, 0, 16'h003C};
        tbl[3]  = '{0, 16, 32'h87FF,   0, 0, 16'h0000};
        tbl[4]  = '{0, 16, 32'h0700,   0, 0, 16'h0000};
        tbl[5]  = '{0, 16, 32'h0000,   0, 0, 16'h00A5};
        tbl[6]  = '{0, 12, 32'h081A,   0, 1, 16'h0000};
        tbl[7]  = '{0, 17, 32'h1035B,  0, 1, 16'h0000};
        tbl[8]  = '{0, 0,  32'h0,      0, 0, 16'h0000};
        tbl[9]  = '{0, 7,  32'h41,     0, 1, 16'h0000};
        tbl[10] = '{0, 18, 32'h0C00,   0, 1, 16'h003C};
        tbl[11] = '{1, 24, 32'h87BEEF, 1, 0, 16'h0000};
        tbl[12] = '{1, 24, 32'h070000, 0, 0, 16'hBEEF};
        tbl[13] = '{1, 24, 32'h0C0000, 0, 0, 16'h0000};
        tbl[14] = '{1, 16, 32'h8712,   0, 1, 16'h0000};
        for (int t = 0; t < 15; t++) begin
            tag = $sformatf("table%0d", t);
            do_frame(tbl[t].s, tbl[t].nbits, tbl[t].bits, 1'b1, tbl[t].stb, tbl[t].err, tbl[t].rd);
        end

        tag = "reset_mid_frame";
        sel = 1'b0;
        repeat (4) @(negedge clk);
        s0 = stb_cnt[0]; e0 = err_cnt[0];
        f = 16'h8255;
        ncs = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            copi = f[15-i];
            repeat (H) @(negedge clk);
            sclk = 1'b1;
            repeat (H) @(negedge clk);
            sclk = 1'b0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_regs_a", 128'(flat_a), 128'(0));
        chk("midrst_cipo_oe", 128'(oe_a), 128'(0));
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        ncs = 1'b1;
        repeat (12) @(negedge clk);
        chk("midrst_strobe", 128'(stb_cnt[0] - s0), 128'(0));
        chk("midrst_err", 128'(err_cnt[0] - e0), 128'(0));
        chk("midrst_regs_a_after", 128'(flat_a), 128'(0));
        chk("midrst_regs_b_after", flat_b, 128'(0));
        chk("midrst_wr_addr", 128'(wa_a), 128'(0));
        for (int s = 0; s < 2; s++) begin
            m_last_addr[s] = '0;
            for (int i = 0; i < 8; i++) m_regs[s][i] = '0;
        end
        tag = "write_after_reset";
        do_frame(0, 16, 32'h8255, 1'b1, 1, 0, 16'h0000);

        for (int n = 0; n < 40; n++) begin
            int s, W, N, FL, nb, r;
            logic rw1;
            logic [6:0] a7;
            logic [31:0] b;
            s  = int'($urandom_range(0, 1));
            W  = (s != 0) ? 16 : 8;
            N  = (s != 0) ? 8 : 5;
            FL = 8 + W;
            r  = int'($urandom_range(0, 9));
            if (r < 7) nb = FL;
            else if (r == 7) nb = int'($urandom_range(1, FL - 1));
            else if (r == 8) nb = FL + int'($urandom_range(1, 3));
            else nb = 0;
            rw1 = 1'($urandom_range(0, 1));
            a7  = 7'($urandom_range(0, N + 2));
            if ($urandom_range(0, 9) == 0) a7 = 7'h7f;
            b = $urandom;
            b = b & ((32'h1 << nb) - 32'h1);
            if (nb >= 8) b = (b & ((32'h1 << (nb - 8)) - 32'h1)) | (32'({rw1, a7}) << (nb - 8));
            tag = $sformatf("rand%0d", n);
            do_frame(s, nb, b, 1'b0, 0, 0, 16'h0000);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
